// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution row scheduler.
package conv_pkg;

   localparam int unsigned IdxW = 11;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StAccum,
      StOutput,
      StDone
   } state_e;

   function automatic int unsigned mac_cycles(input int unsigned d, input int unsigned f);
      return d * f * f + 2;
   endfunction

   function automatic int unsigned out_rows(input int unsigned h, input int unsigned f);
      return h - f + 1;
   endfunction

   function automatic int unsigned slices(input int unsigned h, input int unsigned f);
      return 2 * out_rows(h, f);
   endfunction

endpackage

// File: rtl/conv_row_scheduler_if.sv
// Valid/ready slice result stream from the scheduler to its consumer.
interface conv_row_scheduler_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NU         = 14
);
   import conv_pkg::*;

   logic                     out_valid;
   logic                     out_ready;
   logic [IdxW-1:0]          out_index;
   logic [NU*DATA_WIDTH-1:0] out_data;

   modport master (
      output out_valid,
      output out_index,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_index,
      input  out_data,
      output out_ready
   );

endinterface

// File: rtl/conv_slice_counter.sv
// Tracks the current output row, column half and slice index of a pass.
module conv_slice_counter
   import conv_pkg::*;
#(
   parameter int unsigned NU = 14,
   parameter int unsigned H  = 30,
   parameter int unsigned F  = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            advance,
   output logic [IdxW-1:0] row_number,
   output logic [IdxW-1:0] column,
   output logic [IdxW-1:0] out_index,
   output logic            last
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(slices(H, F) - 1);
   localparam logic [IdxW-1:0] NuVal   = IdxW'(NU);

   logic [IdxW-1:0] row_q, row_d;
   logic [IdxW-1:0] col_q, col_d;
   logic [IdxW-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q <= '0;
         col_q <= '0;
         idx_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         idx_q <= idx_d;
      end
   end

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      idx_d = idx_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
         idx_d = '0;
      end else if (advance) begin
         idx_d = idx_q + 1'b1;
         col_d = (col_q == NuVal) ? '0 : NuVal;
         // The row moves on only after its second half has been delivered.
         if (col_q == NuVal) begin
            row_d = row_q + 1'b1;
         end
      end
   end

   assign row_number = row_q;
   assign column     = col_q;
   assign out_index  = idx_q;
   assign last       = (idx_q == LastIdx);

endmodule

// File: rtl/conv_row_scheduler.sv
// Sequences clear/accumulate/output for every row half of a layer pass.
module conv_row_scheduler
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned D          = 1,
   parameter int unsigned H          = 30,
   parameter int unsigned W          = 30,
   parameter int unsigned F          = 3,
   parameter int unsigned NU         = (W - F + 1) / 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic [IdxW-1:0]          row_number,
   output logic [IdxW-1:0]          column,
   output logic                     cu_reset,
   input  logic [NU*DATA_WIDTH-1:0] cu_results,
   conv_row_scheduler_if.master     out_if
);

   localparam int unsigned MacCycles = mac_cycles(D, F);
   localparam int unsigned CntW      = $clog2(MacCycles) + 1;
   localparam logic [CntW-1:0] MacLast = CntW'(MacCycles - 1);

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [NU*DATA_WIDTH-1:0] data_q, data_d;
   logic [IdxW-1:0]         idx;
   logic                    slice_last;
   logic                    handshake;
   logic                    abort_act;
   logic                    clear;
   logic                    advance;

   assign handshake = (state_q == StOutput) && out_if.out_ready;
   assign abort_act = (state_q != StIdle) && abort;
   // Clearing on the final handshake leaves the position at zero already in DONE.
   assign clear     = ((state_q == StIdle) && start) || abort_act || (handshake && slice_last);
   assign advance   = handshake && !abort;

   conv_slice_counter #(
      .NU (NU),
      .H  (H),
      .F  (F)
   ) u_slice_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .advance    (advance),
      .row_number (row_number),
      .column     (column),
      .out_index  (idx),
      .last       (slice_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StClear;
         StClear:  state_d = StAccum;
         StAccum:  if (cnt_q == MacLast) state_d = StOutput;
         StOutput: if (out_if.out_ready) state_d = slice_last ? StDone : StClear;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      if (abort_act) begin
         state_d = StIdle;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      if (state_q == StClear) begin
         cnt_d = '0;
      end else if (state_q == StAccum) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == MacLast) begin
            data_d = cu_results;
         end
      end
   end

   always_comb begin
      busy             = (state_q != StIdle);
      done             = (state_q == StDone);
      cu_reset         = (state_q != StAccum);
      out_if.out_valid = (state_q == StOutput);
      out_if.out_index = idx;
      out_if.out_data  = data_q;
   end

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler: default geometry plus a D=2, F=5, 8x8 instance.
module tb_conv_row_scheduler;
   import conv_pkg::*;

   localparam int unsigned DW  = 16;
   localparam int unsigned NU1 = 14;
   localparam int unsigned NU2 = 2;

   logic clk = 1'b0;
   logic reset;
   logic start, abort, start2;
   logic busy, done, cu_reset, busy2, done2, cu_reset2;
   logic [IdxW-1:0] row_number, column, row2, col2;
   logic [NU1*DW-1:0] cu_results;
   logic [NU2*DW-1:0] cu_results2;

   conv_row_scheduler_if #(.DATA_WIDTH(DW), .NU(NU1)) oif ();
   conv_row_scheduler_if #(.DATA_WIDTH(DW), .NU(NU2)) oif2 ();

   conv_row_scheduler #(
      .DATA_WIDTH (DW), .D (1), .H (30), .W (30), .F (3), .NU (NU1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .row_number (row_number),
      .column     (column),
      .cu_reset   (cu_reset),
      .cu_results (cu_results),
      .out_if     (oif)
   );

   conv_row_scheduler #(
      .DATA_WIDTH (DW), .D (2), .H (8), .W (8), .F (5), .NU (NU2)
   ) dut2 (
      .clk        (clk),
      .reset      (reset),
      .start      (start2),
      .abort      (1'b0),
      .busy       (busy2),
      .done       (done2),
      .row_number (row2),
      .column     (col2),
      .cu_reset   (cu_reset2),
      .cu_results (cu_results2),
      .out_if     (oif2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int busy;
      int done;
      int valid;
      int cu_reset;
      int row;
      int col;
      int idx;
   } vec_t;

   vec_t tbl[10];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   c;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, c);
      end
   endtask

   task automatic chk_w(input string name, input logic [NU1*DW-1:0] act,
                        input logic [NU1*DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, c);
      end
   endtask

   function automatic logic [NU1*DW-1:0] pat(input int unsigned s);
      logic [NU1*DW-1:0] v;
      for (int i = 0; i < int'(NU1); i++) begin
         v[i*DW +: DW] = 16'(s * 31 + i * 257);
      end
      return v;
   endfunction

   task automatic step();
      @(negedge clk);
      c++;
   endtask

   // Called at a negedge with the DUT idle; returns observing cycle 1.
   task automatic kick1();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, first_v, dn, dcyc;

      tbl[0] = '{cyc: 1,   busy: 1, done: 0, valid: 0, cu_reset: 1, row: 0,  col: 0,  idx: 0};
      tbl[1] = '{cyc: 2,   busy: 1, done: 0, valid: 0, cu_reset: 0, row: 0,  col: 0,  idx: 0};
      tbl[2] = '{cyc: 12,  busy: 1, done: 0, valid: 0, cu_reset: 0, row: 0,  col: 0,  idx: 0};
      tbl[3] = '{cyc: 13,  busy: 1, done: 0, valid: 1, cu_reset: 1, row: 0,  col: 0,  idx: 0};
      tbl[4] = '{cyc: 14,  busy: 1, done: 0, valid: 0, cu_reset: 1, row: 0,  col: 14, idx: 1};
      tbl[5] = '{cyc: 26,  busy: 1, done: 0, valid: 1, cu_reset: 1, row: 0,  col: 14, idx: 1};
      tbl[6] = '{cyc: 27,  busy: 1, done: 0, valid: 0, cu_reset: 1, row: 1,  col: 0,  idx: 2};
      tbl[7] = '{cyc: 728, busy: 1, done: 0, valid: 1, cu_reset: 1, row: 27, col: 14, idx: 55};
      tbl[8] = '{cyc: 729, busy: 1, done: 1, valid: 0, cu_reset: 1, row: 0,  col: 0,  idx: 0};
      tbl[9] = '{cyc: 730, busy: 0, done: 0, valid: 0, cu_reset: 1, row: 0,  col: 0,  idx: 0};

      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      start2 = 1'b0;
      cu_results = '0;
      cu_results2 = 32'hDEAD_BEEF;
      oif.out_ready = 1'b1;
      oif2.out_ready = 1'b1;
      c = 0;

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(oif.out_valid), 0);
      chk("rst_cu_reset", int'(cu_reset), 1);
      chk("rst_index", int'(oif.out_index), 0);
      chk_w("rst_data", oif.out_data, '0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Full default pass with out_ready held high.
      kick1();
      hs = 0; first_v = 0; dn = 0; dcyc = 0;
      while (c <= 735) begin
         cu_results = pat(c);
         for (int i = 0; i < 10; i++) begin
            if (tbl[i].cyc == c) begin
               chk("tbl_busy", int'(busy), tbl[i].busy);
               chk("tbl_done", int'(done), tbl[i].done);
               chk("tbl_valid", int'(oif.out_valid), tbl[i].valid);
               chk("tbl_cu_reset", int'(cu_reset), tbl[i].cu_reset);
               chk("tbl_row", int'(row_number), tbl[i].row);
               chk("tbl_col", int'(column), tbl[i].col);
               chk("tbl_index", int'(oif.out_index), tbl[i].idx);
            end
         end
         if (oif.out_valid) begin
            if (first_v == 0) first_v = c;
            chk("hs_index", int'(oif.out_index), hs);
            chk("hs_row", int'(row_number), hs / 2);
            chk("hs_col", int'(column), (hs % 2) * 14);
            chk_w("hs_data", oif.out_data, pat(13 * hs + 12));
            hs++;
         end
         if (done) begin
            dn++;
            dcyc = c;
         end
         step();
      end
      chk("first_valid_cycle", first_v, 13);
      chk("handshakes", hs, 56);
      chk("done_pulses", dn, 1);
      chk("done_cycle", dcyc, 729);

      // Five-cycle stall on slice 0, then abort together with a handshake.
      kick1();
      dn = 0;
      while (c <= 36) begin
         cu_results = pat(1000 + c);
         oif.out_ready = !(c >= 13 && c <= 17);
         abort = (c == 31);
         if (done) dn++;
         if (c >= 13 && c <= 18) begin
            chk("stall_valid", int'(oif.out_valid), 1);
            chk_w("stall_data", oif.out_data, pat(1012));
            chk("stall_cu_reset", int'(cu_reset), 1);
            chk("stall_index", int'(oif.out_index), 0);
         end
         if (c == 19) begin
            chk("after_stall_valid", int'(oif.out_valid), 0);
            chk("after_stall_index", int'(oif.out_index), 1);
            chk("after_stall_col", int'(column), 14);
         end
         if (c == 31) begin
            chk("s1_valid", int'(oif.out_valid), 1);
            chk("s1_index", int'(oif.out_index), 1);
            chk_w("s1_data", oif.out_data, pat(1030));
         end
         if (c == 32) begin
            chk("abort_hs_busy", int'(busy), 0);
            chk("abort_hs_valid", int'(oif.out_valid), 0);
            chk("abort_hs_index", int'(oif.out_index), 0);
            chk("abort_hs_row", int'(row_number), 0);
            chk("abort_hs_col", int'(column), 0);
            chk("abort_hs_cu_reset", int'(cu_reset), 1);
         end
         step();
      end
      abort = 1'b0;
      oif.out_ready = 1'b1;
      chk("abort_hs_no_done", dn, 0);

      // Abort during ACCUM of slice 0, then restart.
      kick1();
      dn = 0;
      while (c <= 10) begin
         abort = (c == 7);
         if (done) dn++;
         if (c == 8) begin
            chk("abort7_busy", int'(busy), 0);
            chk("abort7_valid", int'(oif.out_valid), 0);
            chk("abort7_cu_reset", int'(cu_reset), 1);
            chk("abort7_index", int'(oif.out_index), 0);
            chk("abort7_row", int'(row_number), 0);
            chk("abort7_col", int'(column), 0);
         end
         step();
      end
      abort = 1'b0;
      chk("abort7_no_done", dn, 0);
      kick1();
      while (c <= 13) begin
         if (c == 12) chk("restart_valid_c12", int'(oif.out_valid), 0);
         if (c == 13) begin
            chk("restart_valid_c13", int'(oif.out_valid), 1);
            chk("restart_index", int'(oif.out_index), 0);
            chk("restart_row", int'(row_number), 0);
         end
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("restart_abort_busy", int'(busy), 0);

      // Starts during a pass are ignored; asynchronous reset at slice 10.
      kick1();
      while (c < 135) begin
         cu_results = pat(2000 + c);
         start = (c == 5 || c == 13 || c == 50 || c == 100);
         if (c == 130) begin
            chk("s9_valid", int'(oif.out_valid), 1);
            chk("s9_index", int'(oif.out_index), 9);
            chk_w("s9_data", oif.out_data, pat(2129));
         end
         step();
      end
      start = 1'b0;
      chk("s10_index", int'(oif.out_index), 10);
      chk("s10_row", int'(row_number), 5);
      chk("s10_col", int'(column), 0);
      chk("s10_busy", int'(busy), 1);
      chk("s10_cu_reset", int'(cu_reset), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_valid", int'(oif.out_valid), 0);
      chk("arst_cu_reset", int'(cu_reset), 1);
      chk("arst_row", int'(row_number), 0);
      chk("arst_col", int'(column), 0);
      chk("arst_index", int'(oif.out_index), 0);
      chk_w("arst_data", oif.out_data, '0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_valid", int'(oif.out_valid), 0);

      // Second geometry: D=2, F=5, 8x8.
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      c = 1;
      hs = 0; first_v = 0; dn = 0; dcyc = 0;
      while (c <= 440) begin
         if (oif2.out_valid) begin
            if (first_v == 0) first_v = c;
            chk("g2_index", int'(oif2.out_index), hs);
            chk("g2_row", int'(row2), hs / 2);
            chk("g2_col", int'(col2), (hs % 2) * 2);
            chk_w("g2_data", {192'b0, oif2.out_data}, {192'b0, 32'hDEAD_BEEF});
            hs++;
         end
         if (done2) begin
            dn++;
            dcyc = c;
         end
         step();
      end
      chk("g2_first_valid", first_v, 54);
      chk("g2_handshakes", hs, 8);
      chk("g2_done_pulses", dn, 1);
      chk("g2_done_cycle", dcyc, 433);
      chk("g2_busy_end", int'(busy2), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_row_scheduler.md
# conv_row_scheduler

Sequencing controller for a bank of convolution units that together compute one half of an output row per pass. It steps through every output row and column half in order. For each slice it clears the units, lets them accumulate for the fixed MAC window, then captures their results and presents them on a valid/ready output stream. It sits between the layer-level control (start/done) and the conv-unit bank plus receptive-field selector, and it replaces free-running row counting with a handshaked, abortable sequence.

## Interface
- DATA_WIDTH, 16, width of one result pixel
- D, 1, filter depth
- H, 30, image height
- W, 30, image width; W-F+1 must be even
- F, 3, filter size
- NU, (W-F+1)/2, conv units in the bank (pixels per slice)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  synchronous cancel of a pass in progress
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse after the last slice handshake
- row_number  out  11  output row being computed (to selector)
- column  out  11  0 or NU, starting output column of the slice (to selector)
- cu_reset  out  1  active-high clear to conv units
- cu_results  in  NU*DATA_WIDTH  conv-unit bank results
- out_valid  out  1  slice result available
- out_ready  in  1  consumer accepts slice
- out_index  out  11  slice number 0..2*(H-F+1)-1
- out_data  out  NU*DATA_WIDTH  captured slice

## Operation
- Constants: MAC_CYCLES = D*F*F+2; OUT_ROWS = H-F+1; SLICES = 2*OUT_ROWS.
- States:
  - IDLE: cu_reset=1. start -> CLEAR, with row, column and index cleared to 0.
  - CLEAR: cu_reset=1 for exactly 1 cycle. Then -> ACCUM, with the counter cleared to 0.
  - ACCUM: cu_reset=0. The counter increments each cycle. When counter==MAC_CYCLES-1, cu_results are registered into out_data and the state moves to OUTPUT.
  - OUTPUT: out_valid=1 and cu_reset=1. out_data, out_index, row_number and column are held stable until out_valid&&out_ready. On that handshake:
    - last slice (index==SLICES-1) -> DONE;
    - otherwise index+1; column toggles 0<->NU; row_number+1 when column was NU; -> CLEAR.
  - DONE: done=1 for 1 cycle, row, column and index return to 0, -> IDLE.
- abort in any non-IDLE state -> IDLE on the next edge:
  - out_valid drops and cu_reset=1;
  - no done pulse is produced;
  - row, column and index return to 0.
- abort has priority over a same-cycle handshake.
- start while busy is ignored. start and abort both high in IDLE: start wins, since abort is only acted on outside IDLE.
- out_valid never deasserts without a handshake, except on abort or reset.

## Timing
- Reset values:
  - busy, done, out_valid = 0;
  - row_number, column, out_index, out_data = 0;
  - cu_reset = 1.
- start seen at edge 0. CLEAR occupies cycle 1 and ACCUM occupies cycles 2..MAC_CYCLES+1. out_valid first rises at cycle MAC_CYCLES+2, which is cycle 13 for D=1, F=3.
- With out_ready held high, each slice takes MAC_CYCLES+2 cycles. For the defaults that is 13 cycles per slice, and the full pass of 56 slices takes 728 cycles. done pulses in the cycle after the last handshake.
- Each cycle with out_ready low in OUTPUT adds exactly one cycle. The conv units stay cleared during the stall.
- Mid-pass reset clears everything asynchronously. The next pass requires a fresh start.

## Structure
- Package conv_pkg holds:
  - state enum (IDLE, CLEAR, ACCUM, OUTPUT, DONE);
  - functions mac_cycles(D,F), out_rows(H,F), slices(H,F);
  - the index/row/column width constant (11).
- One sub-module, conv_slice_counter, holds row_number, column and out_index. It has inputs clear and advance and outputs row_number, column, out_index and last.
- The FSM, MAC counter and output register stay in the top.

## Test plan
- Defaults with out_ready=1 and one start pulse: out_valid rises at cycle 13, 56 handshakes occur, out_index runs 0..55, (row,column) runs (0,0),(0,14),(1,0)…(27,14), done is high at cycle 729 only, and busy falls after it.
- cu_results driven with a per-slice tag: each out_data equals the cu_results value at the last ACCUM cycle, and it is held unchanged through a 5-cycle out_ready stall. That slice takes 18 cycles.
- abort at cycle 7 (ACCUM, slice 0): IDLE next cycle, no done, busy=0, row/column/index=0. A subsequent start restarts at slice 0.
- abort and out_ready asserted in the same cycle during OUTPUT: no index advance and no done.
- start pulses during a pass and reset asserted at slice 10: starts are ignored. Reset yields all outputs at reset values immediately, with cu_reset=1.
- D=2, F=5, H=W=8: MAC_CYCLES=52, NU=2, SLICES=8, and the first out_valid comes at cycle 54.
